// File: rtl/cdc_xfer_pkg.sv
// Shared state encoding and default sizing for the CDC transfer arbiter.
package cdc_xfer_pkg;

    localparam int DEF_N_REQ         = 4;
    localparam int DEF_WIDTH         = 32;
    localparam int DEF_SETTLE_CYCLES = 2;
    localparam int DEF_TIMEOUT       = 1023;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_TOGGLE,
        ST_WAIT_ACK
    } xfer_state_t;

endpackage

// File: rtl/cdc_xfer_arbiter_rr_arb.sv
// Combinational round-robin picker: first set request at or after ptr wins.
module rr_arb #(
    parameter  int N_REQ = 4,
    localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    idx
);

    logic found;
    int   j;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(ptr) + k) % N_REQ;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/cdc_xfer_arbiter.sv
// Arbitrates N requesters onto a single toggle-handshake crossing; payload is
// held stable from load until the destination acks the xfer_req toggle.
module cdc_xfer_arbiter
    import cdc_xfer_pkg::*;
#(
    parameter  int N_REQ         = DEF_N_REQ,
    parameter  int WIDTH         = DEF_WIDTH,
    parameter  int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter  int TIMEOUT       = DEF_TIMEOUT,
    localparam int IW            = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   reset_p,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]       xfer_data,
    output logic [IW-1:0]          xfer_id,
    output logic                   xfer_req,
    input  logic                   xfer_ack_sync,
    output logic                   busy,
    output logic                   timeout_err,
    input  logic                   err_clr
);

    localparam int TW = $clog2(TIMEOUT + 1);

    xfer_state_t                  state;
    logic [IW-1:0]                rr_ptr;
    logic [IW-1:0]                win_idx;
    logic [N_REQ-1:0]             win_gnt;
    logic [3:0]                   settle_cnt;
    logic [TW-1:0]                tmo_cnt;
    logic                         tmo_set;
    logic [N_REQ-1:0][WIDTH-1:0]  req_arr;

    for (genvar i = 0; i < N_REQ; i++) begin : g_slice
        assign req_arr[i] = req_data[i*WIDTH +: WIDTH];
    end

    rr_arb #(.N_REQ(N_REQ)) u_rr_arb (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (win_gnt),
        .idx (win_idx)
    );

    // Fires on the cycle the wait counter would reach TIMEOUT.
    assign tmo_set = (state == ST_WAIT_ACK) && (xfer_ack_sync != xfer_req) &&
                     (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            settle_cnt  <= '0;
            tmo_cnt     <= '0;
            req_ready   <= '0;
            xfer_data   <= '0;
            xfer_id     <= '0;
            xfer_req    <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            req_ready <= '0;
            if (tmo_set)
                timeout_err <= 1'b1;
            else if (err_clr)
                timeout_err <= 1'b0;

            case (state)
                // The winner is captured on the IDLE->LOAD edge so req_ready
                // and the loaded payload are both visible during LOAD.
                ST_IDLE: begin
                    if (|req_valid) begin
                        xfer_data <= req_arr[win_idx];
                        xfer_id   <= win_idx;
                        req_ready <= win_gnt;
                        rr_ptr    <= (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + IW'(1);
                        busy      <= 1'b1;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    settle_cnt <= '0;
                    if (SETTLE_CYCLES == 0) begin
                        xfer_req <= ~xfer_req;
                        state    <= ST_TOGGLE;
                    end else begin
                        state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == 4'(SETTLE_CYCLES - 1)) begin
                        xfer_req <= ~xfer_req;
                        state    <= ST_TOGGLE;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                ST_TOGGLE: begin
                    tmo_cnt <= '0;
                    state   <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    // Timeout only flags; the transfer keeps waiting for the ack.
                    if (xfer_ack_sync == xfer_req) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (tmo_cnt != TW'(TIMEOUT)) begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// Directed bench for cdc_xfer_arbiter: grants are checked against a queue of
// expected (requester, payload) pairs filled as each request is driven.
module tb_cdc_xfer_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int S  = 2;
    localparam int TO = 1023;

    logic           clk = 1'b0;
    logic           reset_p;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   xfer_data;
    logic [1:0]     xfer_id;
    logic           xfer_req;
    logic           xfer_ack_sync;
    logic           busy;
    logic           timeout_err;
    logic           err_clr;

    cdc_xfer_arbiter #(.N_REQ(N), .WIDTH(W), .SETTLE_CYCLES(S), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .reset_p       (reset_p),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .xfer_data     (xfer_data),
        .xfer_id       (xfer_id),
        .xfer_req      (xfer_req),
        .xfer_ack_sync (xfer_ack_sync),
        .busy          (busy),
        .timeout_err   (timeout_err),
        .err_clr       (err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [W-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   pulses = 0;
    int   ack_cnt = 0;
    bit   drop_on_accept = 1'b1;
    bit   auto_ack = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock; sample 1 time unit after the rising edge.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (|req_ready) begin
            pulses++;
            if (sb.size() == 0) begin
                chk("unexpected_ready", 64'(req_ready), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("grant_onehot", 64'(req_ready), 64'd1 << e.id);
                chk("xfer_id", 64'(xfer_id), 64'(e.id));
                chk("xfer_data", 64'(xfer_data), 64'(e.data));
            end
            if (drop_on_accept) req_valid = req_valid & ~req_ready;
        end
        if (auto_ack && (xfer_ack_sync != xfer_req)) begin
            if (ack_cnt == 2) begin
                xfer_ack_sync = xfer_req;
                ack_cnt = 0;
            end else begin
                ack_cnt++;
            end
        end
    endtask

    task automatic do_reset();
        reset_p = 1'b1;
        req_valid = '0;
        xfer_ack_sync = 1'b0;
        err_clr = 1'b0;
        step();
        step();
        reset_p = 1'b0;
    endtask

    task automatic request(input int id, input logic [W-1:0] d);
        exp_t e;
        req_data[id*W +: W] = d;
        req_valid[id] = 1'b1;
        e.id = id;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic wait_toggle(output bit ok);
        logic prev;
        prev = xfer_req;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            step();
            if (xfer_req != prev) ok = 1'b1;
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            step();
            if (!busy) ok = 1'b1;
        end
    endtask

    initial begin
        bit ok;
        int p0;
        req_data = '0;
        do_reset();

        // Reset state
        chk("rst_xfer_req", 64'(xfer_req), 64'd0);
        chk("rst_xfer_data", 64'(xfer_data), 64'd0);
        chk("rst_xfer_id", 64'(xfer_id), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_timeout_err", 64'(timeout_err), 64'd0);

        // Single transfer with exact toggle latency
        p0 = pulses;
        request(0, 32'hDEADBEEF);
        step();
        chk("single_xfer_req_e1", 64'(xfer_req), 64'd0);
        step();
        step();
        chk("single_xfer_req_e3", 64'(xfer_req), 64'd0);
        step();
        chk("single_xfer_req_e4", 64'(xfer_req), 64'd1);
        chk("single_data_stable", 64'(xfer_data), 64'hDEADBEEF);
        chk("single_busy_toggle", 64'(busy), 64'd1);
        step();
        chk("single_busy_wait", 64'(busy), 64'd1);
        xfer_ack_sync = 1'b1;
        step();
        chk("single_idle_after_ack", 64'(busy), 64'd0);
        repeat (3) step();
        chk("single_pulse_count", 64'(pulses - p0), 64'd1);

        // Fairness: all requesters held valid from rr_ptr = 0
        do_reset();
        drop_on_accept = 1'b0;
        auto_ack = 1'b1;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = 32'hA000_0000 + 32'(i);
        for (int i = 0; i < 5; i++) begin
            exp_t e;
            e.id = i % N;
            e.data = 32'hA000_0000 + 32'(i % N);
            sb.push_back(e);
        end
        req_valid = '1;
        for (int k = 0; k < 300 && sb.size() != 0; k++) begin
            step();
            if (sb.size() == 0) req_valid = '0;
        end
        chk("fair_all_granted", 64'(sb.size()), 64'd0);
        req_valid = '0;
        wait_idle(ok);
        chk("fair_idle", 64'(ok), 64'd1);

        // Timeout: ack withheld; flag rises exactly after TO wait cycles
        drop_on_accept = 1'b1;
        auto_ack = 1'b0;
        request(2, 32'h1234_5678);
        wait_toggle(ok);
        chk("tmo_toggle_seen", 64'(ok), 64'd1);
        repeat (TO) step();
        chk("tmo_not_yet", 64'(timeout_err), 64'd0);
        step();
        chk("tmo_set", 64'(timeout_err), 64'd1);
        chk("tmo_busy", 64'(busy), 64'd1);
        repeat (5) step();
        chk("tmo_still_waiting", 64'(busy), 64'd1);
        chk("tmo_xfer_data_held", 64'(xfer_data), 64'h1234_5678);
        xfer_ack_sync = xfer_req;
        step();
        chk("tmo_ack_idle", 64'(busy), 64'd0);
        chk("tmo_sticky", 64'(timeout_err), 64'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("tmo_err_clr", 64'(timeout_err), 64'd0);

        // err_clr coinciding with the timeout set: set wins
        request(3, 32'h0BAD_F00D);
        wait_toggle(ok);
        chk("tmo2_toggle_seen", 64'(ok), 64'd1);
        repeat (TO) step();
        err_clr = 1'b1;
        step();
        chk("set_beats_clr", 64'(timeout_err), 64'd1);
        step();
        chk("clr_after_set", 64'(timeout_err), 64'd0);
        err_clr = 1'b0;
        xfer_ack_sync = xfer_req;
        step();
        chk("tmo2_ack_idle", 64'(busy), 64'd0);

        // Async reset during WAIT_ACK, checked before any clock edge
        request(1, 32'hCAFE_0001);
        wait_toggle(ok);
        chk("rst_toggle_seen", 64'(ok), 64'd1);
        step();
        chk("pre_rst_busy", 64'(busy), 64'd1);
        #2;
        reset_p = 1'b1;
        xfer_ack_sync = 1'b0;
        req_valid = '0;
        #1;
        chk("async_xfer_req", 64'(xfer_req), 64'd0);
        chk("async_xfer_data", 64'(xfer_data), 64'd0);
        chk("async_xfer_id", 64'(xfer_id), 64'd0);
        chk("async_busy", 64'(busy), 64'd0);
        chk("async_req_ready", 64'(req_ready), 64'd0);
        step();
        reset_p = 1'b0;
        repeat (3) step();

        // Stray ack toggle in IDLE is ignored
        xfer_ack_sync = 1'b1;
        repeat (5) step();
        chk("stray_busy", 64'(busy), 64'd0);
        chk("stray_xfer_req", 64'(xfer_req), 64'd0);
        chk("stray_req_ready", 64'(req_ready), 64'd0);

        // Following transfer still has normal latency; ack already matches
        request(3, 32'h3333_3333);
        step();
        step();
        step();
        chk("post_stray_e3", 64'(xfer_req), 64'd0);
        step();
        chk("post_stray_e4", 64'(xfer_req), 64'd1);
        wait_idle(ok);
        chk("post_stray_idle", 64'(ok), 64'd1);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cdc_xfer_arbiter.md
CDC_XFER_ARBITER -- requirements
Module: cdc_xfer_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 32, payload width per requester.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 2, cycles xfer_data is held stable before the xfer_req toggle (0..15).
REQ-004 SHALL have parameter TIMEOUT, default 1023, WAIT_ACK cycles before timeout_err is flagged.
REQ-005 SHALL have port clk  input  1  source-domain clock.
REQ-006 SHALL have port reset_p  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port req_valid  input  N_REQ  per-requester transfer request.
REQ-008 SHALL have port req_data  input  N_REQ*WIDTH  payloads; requester i in bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port req_ready  output  N_REQ  one-hot accept strobe.
REQ-010 SHALL have port xfer_data  output  WIDTH  registered payload driven across the domain boundary.
REQ-011 SHALL have port xfer_id  output  clog2(N_REQ)  index of the requester owning xfer_data.
REQ-012 SHALL have port xfer_req  output  1  request toggle level, fed to an external single-bit synchronizer.
REQ-013 SHALL have port xfer_ack_sync  input  1  destination ack toggle, already synchronized into clk.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port timeout_err  output  1  sticky timeout flag.
REQ-016 SHALL have port err_clr  input  1  clears timeout_err.

Function
REQ-017 SHALL implement FSM IDLE -> LOAD -> SETTLE -> TOGGLE -> WAIT_ACK -> IDLE.
REQ-018 IDLE: if any req_valid is set, SHALL select a winner round-robin, starting from rr_ptr, and enter LOAD; otherwise SHALL stay in IDLE.
REQ-019 LOAD: SHALL register the winner's data and index into xfer_data/xfer_id, pulse req_ready[winner] for exactly one cycle, and set rr_ptr = (winner+1) mod N_REQ.
REQ-020 Requesters SHALL hold req_valid and req_data until req_ready; the arbiter never drops a valid request.
REQ-021 SETTLE: SHALL count SETTLE_CYCLES clk cycles with xfer_data constant; with SETTLE_CYCLES=0 it SHALL pass directly to TOGGLE.
REQ-022 TOGGLE: SHALL invert xfer_req for one cycle, then enter WAIT_ACK.
REQ-023 WAIT_ACK: SHALL return to IDLE in the cycle after xfer_ack_sync == xfer_req; xfer_data and xfer_id SHALL stay stable until then.
REQ-024 Latency: a request in IDLE cycle t SHALL toggle xfer_req at clock edge t+2+SETTLE_CYCLES.
REQ-025 The timeout counter SHALL clear on WAIT_ACK entry, saturate at TIMEOUT, and set timeout_err on reaching TIMEOUT; the FSM SHALL keep waiting (no abort).
REQ-026 err_clr SHALL clear timeout_err; when err_clr and a timeout set occur in the same cycle, set SHALL win.
REQ-027 A toggle seen on xfer_ack_sync outside WAIT_ACK SHALL be ignored and SHALL NOT alter state.
REQ-028 req_valid changes during SETTLE, TOGGLE or WAIT_ACK SHALL NOT affect the transfer in progress.

Reset
REQ-029 On reset_p the block SHALL immediately force: state=IDLE, xfer_req=0, xfer_data=0, xfer_id=0, req_ready=0, busy=0, timeout_err=0, rr_ptr=0, counters=0.
REQ-030 A reset mid-transfer SHALL abandon the transfer without asserting req_ready again; the system SHALL reset the destination side in the same reset event.

Structure
REQ-031 Package cdc_xfer_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-032 Round-robin selection SHALL be a sub-module rr_arb (inputs: request vector and pointer; outputs: one-hot grant and index), purely combinational.
REQ-033 The block SHALL contain no synchronizers; xfer_req/xfer_ack_sync connect to external single-bit synchronizer instances.

Verification
REQ-034 Single transfer: req_valid=4'b0001, data 0xDEADBEEF -> req_ready[0] pulses once, xfer_data=0xDEADBEEF, xfer_req toggles 0->1 at edge t+4, idle 1 cycle after ack_sync=1.
REQ-035 Fairness: all four valid continuously -> grant order 0,1,2,3,0, each req_ready pulse unique.
REQ-036 Timeout: ack withheld 1023 cycles -> timeout_err=1 while busy stays 1; ack then -> IDLE; err_clr -> timeout_err=0.
REQ-037 Simultaneous err_clr and timeout set -> timeout_err=1.
REQ-038 Async reset asserted in WAIT_ACK -> all outputs 0 without a clk edge; stray ack toggle in IDLE -> no state change.
